// File: rtl/ol_layer_scheduler_if.sv
// Bundle between the output-layer scheduler, its upstream source, the shared neuron bus and the downstream sink.
// Valid/ready rule: a transfer occurs on a rising clk edge where valid and ready are both 1; data is sampled only on that edge.
interface ol_layer_scheduler_if #(
  parameter int NUM_INPUTS  = 8,
  parameter int NUM_NEURONS = 4,
  parameter int WIDTH       = 8
);
  logic [NUM_INPUTS*WIDTH-1:0]  in_values;
  logic                         in_valid;
  logic                         in_ready;
  logic [NUM_NEURONS-1:0]       neuron_ready;
  logic [WIDTH-1:0]             neuron_value_in;
  logic                         neuron_valid_in;
  logic [NUM_NEURONS*WIDTH-1:0] neuron_value_out;
  logic [NUM_NEURONS-1:0]       neuron_valid_out;
  logic [NUM_NEURONS-1:0]       neuron_overflow;
  logic [NUM_NEURONS*WIDTH-1:0] out_values;
  logic                         out_valid;
  logic                         out_ready;
  logic                         out_overflow;
  logic                         timeout_err;
  logic [2:0]                   dbg_state;

  modport master (
    input  in_values, in_valid, neuron_ready, neuron_value_out, neuron_valid_out,
           neuron_overflow, out_ready,
    output in_ready, neuron_value_in, neuron_valid_in, out_values, out_valid,
           out_overflow, timeout_err, dbg_state
  );

  modport slave (
    output in_values, in_valid, neuron_ready, neuron_value_out, neuron_valid_out,
           neuron_overflow, out_ready,
    input  in_ready, neuron_value_in, neuron_valid_in, out_values, out_valid,
           out_overflow, timeout_err, dbg_state
  );
endinterface

// File: rtl/ol_layer_scheduler.sv
// Output-layer scheduler: takes one input vector, broadcasts it serially to every neuron,
// gathers each neuron's result and hands back the assembled vector with overflow/timeout status.
module ol_layer_scheduler #(
  parameter int NUM_INPUTS  = 8,
  parameter int NUM_NEURONS = 4,
  parameter int WIDTH       = 8,
  parameter int TIMEOUT     = 255
) (
  input logic                clk,
  input logic                rstn,
  ol_layer_scheduler_if.master bus
);
  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_READY = 3'd1,
    S_STREAM     = 3'd2,
    S_WAIT_DONE  = 3'd3,
    S_DRAIN      = 3'd4,
    S_OUTPUT     = 3'd5
  } state_t;

  state_t                       state;
  logic [WIDTH-1:0]             data [NUM_INPUTS];
  logic [IDX_W-1:0]             idx;
  logic [TO_W-1:0]              to_cnt;
  logic [NUM_NEURONS-1:0]       done;
  logic [NUM_NEURONS*WIDTH-1:0] results;
  logic                         ovf;
  logic                         to_err;

  logic                         capture_en;
  logic [NUM_NEURONS-1:0]       new_hits;
  logic [NUM_NEURONS-1:0]       done_next;

  // Results may already arrive while the tail of the vector is still streaming.
  always_comb begin
    capture_en = (state == S_STREAM) || (state == S_WAIT_DONE);
    new_hits   = capture_en ? (bus.neuron_valid_out & ~done) : '0;
    done_next  = done | new_hits;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= S_IDLE;
      idx     <= '0;
      to_cnt  <= '0;
      done    <= '0;
      results <= '0;
      ovf     <= 1'b0;
      to_err  <= 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) data[i] <= '0;
    end else begin
      for (int j = 0; j < NUM_NEURONS; j++) begin
        if (new_hits[j]) results[j*WIDTH +: WIDTH] <= bus.neuron_value_out[j*WIDTH +: WIDTH];
      end
      done <= done_next;

      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            for (int i = 0; i < NUM_INPUTS; i++) data[i] <= bus.in_values[i*WIDTH +: WIDTH];
            done    <= '0;
            results <= '0;
            ovf     <= 1'b0;
            to_err  <= 1'b0;
            idx     <= '0;
            to_cnt  <= '0;
            state   <= S_WAIT_READY;
          end
        end
        S_WAIT_READY: begin
          if (&bus.neuron_ready) state <= S_STREAM;
        end
        S_STREAM: begin
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= S_WAIT_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          ovf <= ovf | (|bus.neuron_overflow);
          if (&done_next) begin
            state <= S_DRAIN;
          end else if (to_cnt == TO_LAST) begin
            to_err <= 1'b1;
            state  <= S_DRAIN;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          // Neurons flag overflow one cycle after their result; this cycle catches the last one.
          ovf   <= ovf | (|bus.neuron_overflow);
          state <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready        = (state == S_IDLE);
  assign bus.neuron_valid_in = (state == S_STREAM);
  assign bus.neuron_value_in = (state == S_STREAM) ? data[idx] : '0;
  assign bus.out_values      = results;
  assign bus.out_valid       = (state == S_OUTPUT);
  assign bus.out_overflow    = ovf;
  assign bus.timeout_err     = to_err;
  assign bus.dbg_state       = state;
endmodule

// File: tb/tb_ol_layer_scheduler.sv
// Bench for ol_layer_scheduler: directed vector table, mid-stream reset, then random vectors against a timeline model.
module tb_ol_layer_scheduler;
  localparam int NI = 8;
  localparam int NN = 4;
  localparam int W  = 8;
  localparam int TO = 20;

  typedef struct {
    logic [NI*W-1:0]     in_vec;
    logic [NN-1:0][7:0]  rdy_low;   // cycles after acceptance that neuron j holds READY low
    logic [NN-1:0][7:0]  done_d;    // result pulse, cycles after the last stream cycle; FF = never
    logic [NN-1:0][7:0]  val;
    logic [NN-1:0]       ovf;       // neuron raises overflow the cycle after its pulse
    logic [7:0]          dup_d;     // second pulse of neuron 0; FF = none
    logic [7:0]          dup_val;
    int                  stall;
    logic [NN*W-1:0]     exp_out;
    bit                  exp_ovf;
    bit                  exp_err;
    int                  exp_lat;   // cycle (0 = after accept edge) where OUT_VALID is first high
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [W-1:0] exp_q[$];
  vec_t tbl[8];

  always #5 clk = ~clk;

  ol_layer_scheduler_if #(.NUM_INPUTS(NI), .NUM_NEURONS(NN), .WIDTH(W)) bus ();

  ol_layer_scheduler #(.NUM_INPUTS(NI), .NUM_NEURONS(NN), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int stream_start(input vec_t v);
    int s = 1;
    for (int j = 0; j < NN; j++)
      if (int'(v.rdy_low[j]) + 1 > s) s = int'(v.rdy_low[j]) + 1;
    return s;
  endfunction

  // Timeline model: WAIT_DONE spans cycles ws .. ws+TO-1; a result counts if its first pulse lands by then.
  function automatic void model(input vec_t v, output logic [NN*W-1:0] eo, output bit eovf,
                                output bit eerr, output int elat);
    int ws, last, drain, p;
    bit full;
    ws = stream_start(v) + NI;
    last = ws;
    full = 1'b1;
    eo = '0;
    eovf = 1'b0;
    for (int j = 0; j < NN; j++) begin
      if (v.done_d[j] == 8'hFF) full = 1'b0;
      else begin
        p = ws - 1 + int'(v.done_d[j]);
        if (p <= ws + TO - 1) begin
          eo[j*W +: W] = v.val[j];
          if (p > last) last = p;
        end else full = 1'b0;
      end
    end
    drain = full ? last + 1 : ws + TO;
    for (int j = 0; j < NN; j++)
      if (v.ovf[j] && v.done_d[j] != 8'hFF && ws + int'(v.done_d[j]) <= drain) eovf = 1'b1;
    eerr = !full;
    elat = drain + 1;
  endfunction

  function automatic vec_t mk(input logic [63:0] in_vec, input logic [31:0] rdy, input logic [31:0] dd,
                             input logic [31:0] vals, input logic [3:0] ovf, input logic [7:0] dup_d,
                             input logic [7:0] dup_val, input int stall, input logic [31:0] eo,
                             input bit eovf, input bit eerr, input int lat);
    vec_t v;
    v.in_vec = in_vec; v.rdy_low = rdy; v.done_d = dd; v.val = vals; v.ovf = ovf;
    v.dup_d = dup_d; v.dup_val = dup_val; v.stall = stall;
    v.exp_out = eo; v.exp_ovf = eovf; v.exp_err = eerr; v.exp_lat = lat;
    return v;
  endfunction

  task automatic wait_in_ready(input string name);
    int n = 0;
    while (!bus.in_ready && n < 100) begin
      step();
      n++;
    end
    check(name, bus.in_ready, 1'b1);
  endtask

  task automatic run_vector(input vec_t v, input int tag);
    int s, lat, n_strobes;
    int pulse[NN];
    int dpulse;
    bit vo;
    s = stream_start(v);
    lat = v.exp_lat;
    for (int j = 0; j < NN; j++)
      pulse[j] = (v.done_d[j] == 8'hFF) ? -1000 : s + NI - 1 + int'(v.done_d[j]);
    dpulse = (v.dup_d == 8'hFF) ? -1000 : s + NI - 1 + int'(v.dup_d);
    n_strobes = 0;
    exp_q.delete();

    wait_in_ready($sformatf("v%0d in_ready_idle", tag));
    bus.in_values = v.in_vec;
    bus.in_valid = 1'b1;
    bus.neuron_ready = '1;
    bus.neuron_valid_out = '0;
    bus.neuron_overflow = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < NI; i++) exp_q.push_back(v.in_vec[i*W +: W]);
    step();
    bus.in_valid = 1'b0;
    bus.in_values = {$urandom, $urandom};

    for (int t = 0; t <= lat + v.stall; t++) begin
      check($sformatf("v%0d t%0d valid_in", tag, t), bus.neuron_valid_in, (t >= s && t < s + NI));
      if (bus.neuron_valid_in) begin
        n_strobes++;
        if (exp_q.size() > 0) check($sformatf("v%0d t%0d value_in", tag, t), bus.neuron_value_in, exp_q.pop_front());
      end
      check($sformatf("v%0d t%0d in_ready", tag, t), bus.in_ready, 1'b0);
      if (t < lat) begin
        check($sformatf("v%0d t%0d out_valid", tag, t), bus.out_valid, 1'b0);
      end else begin
        check($sformatf("v%0d t%0d out_valid", tag, t), bus.out_valid, 1'b1);
        check($sformatf("v%0d t%0d out_values", tag, t), bus.out_values, v.exp_out);
        check($sformatf("v%0d t%0d out_overflow", tag, t), bus.out_overflow, v.exp_ovf);
        check($sformatf("v%0d t%0d timeout_err", tag, t), bus.timeout_err, v.exp_err);
      end

      for (int j = 0; j < NN; j++) begin
        bus.neuron_ready[j] = (t >= s) ? 1'($urandom_range(0, 1)) : (t >= int'(v.rdy_low[j]));
        vo = (t == pulse[j]) || (j == 0 && t == dpulse);
        bus.neuron_value_out[j*W +: W] = (j == 0 && t == dpulse) ? v.dup_val : (vo ? v.val[j] : 8'($urandom));
        if ((t < s || t >= lat - 1) && $urandom_range(0, 3) == 0) vo = 1'b1;
        bus.neuron_valid_out[j] = vo;
        bus.neuron_overflow[j] = (v.ovf[j] && pulse[j] >= 0 && t > pulse[j]) ||
                                 ((t < s + NI || t >= lat) && $urandom_range(0, 3) == 0);
      end
      bus.out_ready = (t < lat) ? 1'($urandom_range(0, 1)) : (t >= lat + v.stall);
      step();
    end
    check($sformatf("v%0d post out_valid", tag), bus.out_valid, 1'b0);
    check($sformatf("v%0d post in_ready", tag), bus.in_ready, 1'b1);
    check($sformatf("v%0d strobe count", tag), n_strobes, NI);
    bus.neuron_valid_out = '0;
    bus.neuron_overflow = '0;
    bus.neuron_ready = '1;
    bus.out_ready = 1'b0;
  endtask

  task automatic reset_mid_stream(input logic [NI*W-1:0] vec);
    wait_in_ready("rst in_ready_idle");
    bus.in_values = vec;
    bus.in_valid = 1'b1;
    bus.neuron_ready = '1;
    bus.neuron_valid_out = '0;
    bus.neuron_overflow = '0;
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("rst pre value_in idx3", bus.neuron_value_in, vec[3*W +: W]);
    check("rst pre valid_in", bus.neuron_valid_in, 1'b1);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    check("rst valid_in", bus.neuron_valid_in, 1'b0);
    check("rst in_ready", bus.in_ready, 1'b1);
    check("rst value_in", bus.neuron_value_in, '0);
    check("rst out_valid", bus.out_valid, 1'b0);
    check("rst out_values", bus.out_values, '0);
    check("rst out_overflow", bus.out_overflow, 1'b0);
    check("rst timeout_err", bus.timeout_err, 1'b0);
    step();
    check("rst no resume", bus.neuron_valid_in, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [NN*W-1:0] eo;
    bit eovf, eerr;
    int elat;

    bus.in_values = '0;
    bus.in_valid = 1'b0;
    bus.neuron_ready = '0;
    bus.neuron_value_out = '0;
    bus.neuron_valid_out = '0;
    bus.neuron_overflow = '0;
    bus.out_ready = 1'b0;
    rstn = 1'b0;
    step();
    step();
    check("reset in_ready", bus.in_ready, 1'b1);
    check("reset out_valid", bus.out_valid, 1'b0);
    check("reset valid_in", bus.neuron_valid_in, 1'b0);
    check("reset value_in", bus.neuron_value_in, '0);
    check("reset out_values", bus.out_values, '0);
    check("reset out_overflow", bus.out_overflow, 1'b0);
    check("reset timeout_err", bus.timeout_err, 1'b0);
    rstn = 1'b1;
    step();

    //             in_vec                  rdy_low      done_d       vals         ovf   dup    dupv   st  exp_out      ov err lat
    tbl[0] = mk(64'h0807060504030201, 32'h00000000, 32'h05050505, 32'h44332211, 4'h0, 8'hFF, 8'h00, 0, 32'h44332211, 0, 0, 15);
    tbl[1] = mk(64'hF0E1D2C3B4A59687, 32'h00030000, 32'h0C070702, 32'h44332211, 4'h0, 8'hFF, 8'h00, 0, 32'h44332211, 0, 0, 25);
    tbl[2] = mk(64'h1122334455667788, 32'h00000000, 32'h06050903, 32'hD4C3B2A1, 4'h2, 8'hFF, 8'h00, 2, 32'hD4C3B2A1, 1, 0, 19);
    tbl[3] = mk(64'h8877665544332211, 32'h00000000, 32'h05050505, 32'h807F01FF, 4'h0, 8'hFF, 8'h00, 0, 32'h807F01FF, 0, 0, 15);
    tbl[4] = mk(64'h0102030405060708, 32'h00000000, 32'hFF040302, 32'h44332211, 4'h0, 8'hFF, 8'h00, 1, 32'h00332211, 0, 1, 30);
    tbl[5] = mk(64'hA5A55A5A0F0FF0F0, 32'h00000000, 32'h06050302, 32'h4433225A, 4'h0, 8'h04, 8'hA5, 10, 32'h4433225A, 0, 0, 16);
    tbl[6] = mk(64'hDEADBEEFCAFEF00D, 32'h00000000, 32'h14010101, 32'h9988AABB, 4'h0, 8'hFF, 8'h00, 0, 32'h9988AABB, 0, 0, 30);
    tbl[7] = mk(64'h0123456789ABCDEF, 32'h00000000, 32'h00000000, 32'hC0DEFACE, 4'h0, 8'hFF, 8'h00, 0, 32'hC0DEFACE, 0, 0, 11);

    for (int i = 0; i < 8; i++) run_vector(tbl[i], i);

    reset_mid_stream(64'h0807060504030201);
    v = tbl[0];
    v.in_vec = 64'h1817161514131211;
    run_vector(v, 100);

    for (int k = 0; k < 40; k++) begin
      v.in_vec = {$urandom, $urandom};
      for (int j = 0; j < NN; j++) begin
        v.rdy_low[j] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 5)) : 8'd0;
        v.done_d[j] = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 22));
        v.val[j] = 8'($urandom);
        v.ovf[j] = ($urandom_range(0, 4) == 0);
      end
      if (v.done_d[0] != 8'hFF && $urandom_range(0, 2) == 0) v.dup_d = v.done_d[0] + 8'($urandom_range(1, 3));
      else v.dup_d = 8'hFF;
      v.dup_val = 8'($urandom);
      v.stall = $urandom_range(0, 4);
      model(v, eo, eovf, eerr, elat);
      v.exp_out = eo;
      v.exp_ovf = eovf;
      v.exp_err = eerr;
      v.exp_lat = elat;
      run_vector(v, 200 + k);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ol_layer_scheduler.md
# ol_layer_scheduler

- Sequences one output layer of neurons that all share a single serial input bus.
- Accepts a full input vector through a valid/ready handshake and waits until every neuron reports ready.
- Streams the vector to all neurons one element per cycle, then collects each neuron's result as it completes.
- Returns the assembled output vector with aggregated overflow and timeout status; it sits between the upstream layer (or host) and the array of neuron instances.

## Interface

Parameters:

- NUM_INPUTS, 8, elements per input vector (neuron fan-in), ≥1
- NUM_NEURONS, 4, neurons driven by this scheduler, ≥1
- WIDTH, 8, signed fixed-point element width
- TIMEOUT, 255, maximum cycles spent in WAIT_DONE before abort, ≥1

Ports:

- CLK  in  1  clock; one clock domain; all logic on rising edge
- RSTN  in  1  reset; synchronous, active-low
- IN_VALUES  in  NUM_INPUTS*WIDTH  input vector; element i at [i*WIDTH +: WIDTH]
- IN_VALID  in  1  input vector valid
- IN_READY  out  1  scheduler can accept a vector
- NEURON_READY  in  NUM_NEURONS  per-neuron READY
- NEURON_VALUE_IN  out  WIDTH  broadcast serial element to all neurons
- NEURON_VALID_IN  out  1  broadcast element strobe
- NEURON_VALUE_OUT  in  NUM_NEURONS*WIDTH  per-neuron result
- NEURON_VALID_OUT  in  NUM_NEURONS  per-neuron result strobe (1-cycle pulse)
- NEURON_OVERFLOW  in  NUM_NEURONS  per-neuron sticky overflow
- OUT_VALUES  out  NUM_NEURONS*WIDTH  collected results; neuron j at [j*WIDTH +: WIDTH]
- OUT_VALID  out  1  result vector valid
- OUT_READY  in  1  downstream accepts result
- OUT_OVERFLOW  out  1  OR of all neuron overflows for this vector
- TIMEOUT_ERR  out  1  at least one neuron did not complete within TIMEOUT

## Operation

The state machine has six states: IDLE, WAIT_READY, STREAM, WAIT_DONE, DRAIN and OUTPUT.

- **IDLE**
  - IN_READY=1.
  - On IN_VALID&IN_READY, capture IN_VALUES, clear the done mask, OUT_VALUES, the overflow flag, the timeout flag and the counters, then go to WAIT_READY.
- **WAIT_READY**
  - Stays here until NEURON_READY is all ones, then goes to STREAM.
- **STREAM**
  - NEURON_VALID_IN=1 for exactly NUM_INPUTS consecutive cycles.
  - NEURON_VALUE_IN = captured element idx, with idx 0..NUM_INPUTS-1.
  - After idx = NUM_INPUTS-1, go to WAIT_DONE.
  - NEURON_READY is ignored in this state.
- **WAIT_DONE**
  - On NEURON_VALID_OUT[j] with done[j]=0, latch NEURON_VALUE_OUT[j] into OUT_VALUES[j] and set done[j].
  - A repeat pulse from a neuron already marked done is ignored; the first value is kept.
  - Multiple neurons completing in the same cycle are all captured.
  - When the done mask, including this cycle's captures, is all ones, go to DRAIN.
  - A timeout counter increments every cycle in this state. When it reaches TIMEOUT-1 with the mask not full, set TIMEOUT_ERR and go to DRAIN. Missing entries of OUT_VALUES stay 0.
- **DRAIN**
  - Lasts one cycle and exists to absorb the neurons' registered overflow.
  - Then go to OUTPUT.
- **OUTPUT**
  - OUT_VALID=1; OUT_VALUES, OUT_OVERFLOW and TIMEOUT_ERR are held stable.
  - On OUT_READY, go to IDLE.
- **Result capture outside WAIT_DONE:** NEURON_VALID_OUT pulses arriving during STREAM are captured the same way as in WAIT_DONE. Pulses in all other states are ignored.
- **Overflow:** the overflow flag ORs NEURON_OVERFLOW every cycle in WAIT_DONE and DRAIN, is sticky until the next accepted input, and drives OUT_OVERFLOW.
- **Reset:** RSTN low at any edge, including mid-STREAM or in OUTPUT, forces IDLE on that edge.
  - All outputs reset to 0, except IN_READY, which is 1 from the first cycle after reset.
  - Counters, the done mask and captured data are cleared.
  - No partial stream is resumed.

## Timing

- All outputs are registered, or decoded directly from the state register.
- **Handshakes:**
  - A transfer happens on a rising edge where valid&ready=1.
  - IN_VALUES is sampled only on that edge.
  - OUT_READY is evaluated only while OUT_VALID=1. OUT_READY held high gives a single-cycle OUTPUT.
- **Latency, with the input handshake at edge E and all neurons ready:**
  - WAIT_READY occupies cycle E..E+1.
  - NEURON_VALID_IN is high from edge E+1 through E+NUM_INPUTS.
  - WAIT_DONE is entered at edge E+NUM_INPUTS+1.
  - DRAIN is entered one edge after the last capture; OUT_VALID rises on the edge after that.
  - Back-to-back throughput is one vector per (NUM_INPUTS + neuron latency + 4) cycles minimum.
- **Width rules:**
  - The idx counter is clog2(NUM_INPUTS) bits, minimum 1.
  - The timeout counter is clog2(TIMEOUT+1) bits.
  - No arithmetic is performed on data; values pass through bit-exact, sign preserved.

## Test plan

- **Nominal:** NUM_INPUTS=8, NUM_NEURONS=4, neuron models with 5-cycle latency returning 8'h11, 8'h22, 8'h33, 8'h44.
  - Input vector 8'h01..8'h08.
  - Required: NEURON_VALUE_IN sequence 01..08 on 8 consecutive strobes.
  - Required: OUT_VALUES=44332211, OUT_OVERFLOW=0, TIMEOUT_ERR=0.
- **Staggered readiness and completion:** neuron 2 holds NEURON_READY low for 3 cycles after input acceptance; neurons finish at 2/7/7/12 cycles after the stream ends.
  - Required: stream starts exactly one cycle after NEURON_READY is all ones.
  - Required: OUT_VALID rises 2 cycles after the last pulse.
  - Required: simultaneous captures at 7 are both correct.
- **Overflow:** neuron 1 raises NEURON_OVERFLOW one cycle after its VALID_OUT, and it is the last to finish.
  - Required: OUT_OVERFLOW=1, caught via DRAIN.
  - Required: the next vector, with no overflow, reports 0.
- **Timeout:** TIMEOUT=20, neuron 3 never pulses.
  - Required: OUT_VALID after 20 WAIT_DONE cycles, TIMEOUT_ERR=1, OUT_VALUES[31:24]=0, other entries correct.
- **Duplicate result and back-pressure:** neuron 0 pulses twice, with 8'h5A then 8'hA5; OUT_READY is held low for 10 cycles.
  - Required: OUT_VALUES[7:0]=8'h5A.
  - Required: outputs stable while stalled and IN_READY=0 until the OUT handshake.
- **Reset mid-STREAM:** RSTN low for 1 cycle at idx=3.
  - Required: NEURON_VALID_IN=0 and IN_READY=1 on the following cycle, all outputs 0.
  - Required: a fresh vector then completes normally.
